uart_tx: RTL

//  UART serial transmitter. Sits directly upstream of UART_RX and drives its dataline.

---
 rtl/uart_tx_if.sv | 15 +
 rtl/uart_tx.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: parallel byte handshake feeding the UART transmitter.
//   data  - byte to send, sampled on an edge where valid && ready
//   valid - producer has a byte
//   ready - transmitter can accept a byte (registered in the transmitter)
// master: producer side. slave: transmitter side.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter.
// Takes one byte over a valid/ready handshake and sends one frame:
// start bit, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits.
// The bit period is the runtime baudrate in clocks (0 is treated as 1). It is
// captured at acceptance and held for the whole frame.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset; aborts any frame and idles the line
//   bus      - uart_tx_if.slave: data/valid in, ready out (registered)
//   baudrate - clocks per bit
//   dataline - serial output, idle high (registered)
//   busy     - high while a frame is on the line (registered)
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int BAUD_W    = 16,
  parameter int PARITY    = 0,   // 0 none, 1 even, 2 odd
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_if.slave          bus,
  input  logic [BAUD_W-1:0] baudrate,
  output logic              dataline,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [3:0]        LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]        LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [BAUD_W-1:0] ONE       = BAUD_W'(1);

  state_t                 state;
  logic [DATA_BITS-1:0]   shreg;
  logic [BAUD_W-1:0]      b_l;
  logic [BAUD_W-1:0]      clk_cnt;
  logic [3:0]             bit_cnt;
  logic                   par_bit;
  logic                   ready_q;
  logic [BAUD_W-1:0]      b_eff;

  assign b_eff     = (baudrate == '0) ? ONE : baudrate;
  assign bus.ready = ready_q;

  // clk_cnt is loaded with B-1 at every bit boundary and the bit ends on the
  // edge where it reads 0, so each bit occupies exactly B clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      shreg    <= '0;
      b_l      <= ONE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      par_bit  <= 1'b0;
      ready_q  <= 1'b0;
      dataline <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          dataline <= 1'b1;
          busy     <= 1'b0;
          ready_q  <= 1'b1;
          // ready_q gates acceptance, so the first edge after reset only raises ready.
          if (bus.valid && ready_q) begin
            shreg    <= bus.data;
            b_l      <= b_eff;
            clk_cnt  <= b_eff - ONE;
            bit_cnt  <= '0;
            par_bit  <= (PARITY == 2) ? ~(^bus.data) : (^bus.data);
            dataline <= 1'b0;
            ready_q  <= 1'b0;
            busy     <= 1'b1;
            state    <= S_START;
          end
        end

        S_START: begin
          if (clk_cnt == '0) begin
            dataline <= shreg[0];
            shreg    <= shreg >> 1;
            clk_cnt  <= b_l - ONE;
            bit_cnt  <= '0;
            state    <= S_DATA;
          end else begin
            clk_cnt <= clk_cnt - ONE;
          end
        end

        S_DATA: begin
          if (clk_cnt == '0) begin
            clk_cnt <= b_l - ONE;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                dataline <= par_bit;
                state    <= S_PARITY;
              end else begin
                dataline <= 1'b1;
                state    <= S_STOP;
              end
            end else begin
              dataline <= shreg[0];
              shreg    <= shreg >> 1;
              bit_cnt  <= bit_cnt + 4'd1;
            end
          end else begin
            clk_cnt <= clk_cnt - ONE;
          end
        end

        S_PARITY: begin
          if (clk_cnt == '0) begin
            dataline <= 1'b1;
            clk_cnt  <= b_l - ONE;
            bit_cnt  <= '0;
            state    <= S_STOP;
          end else begin
            clk_cnt <= clk_cnt - ONE;
          end
        end

        S_STOP: begin
          dataline <= 1'b1;
          // Stop bits are counted one B-period at a time so clk_cnt never
          // needs to hold STOP_BITS*B.
          if (clk_cnt == '0) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              ready_q <= 1'b1;
              busy    <= 1'b0;
              state   <= S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              clk_cnt <= b_l - ONE;
            end
          end else begin
            clk_cnt <= clk_cnt - ONE;
          end
        end

        default: begin
          dataline <= 1'b1;
          busy     <= 1'b0;
          ready_q  <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
